mmio_tx_sched: RTL and testbench
================================

# mmio_tx_sched

Sequences CPU MMIO stores onto the two peripherals behind the memory decoder: the hex display register and the UART transmitter. Stores to the UART slot go into a small FIFO. A drain state machine feeds the FIFO to the transmitter one byte at a time using a start/busy handshake. This keeps back-to-back CPU stores from being lost while the UART is still shifting out a frame.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, ≥2.
- BUSY_TIMEOUT, 4 — cycles to wait in WAIT_BUSY for tx_busy to rise before giving up.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mmio_addr  in  1  peripheral select from decoder: 0 = hex display, 1 = UART TX.
- mmio_data  in  16  store data; UART uses [7:0].
- mmio_we  in  1  store strobe, one cycle per store.
- hex_data  out  16  registered hex display value.
- tx_data  out  8  byte presented to transmitter.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_busy  in  1  transmitter busy; high while a frame is shifting.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- drop_cnt  out  8  count of UART stores lost to overflow, saturating.

## Operation
- **Hex path:** when mmio_we=1 and mmio_addr=0, hex_data <= mmio_data. No other effect.
- **UART push:** when mmio_we=1 and mmio_addr=1, mmio_data[7:0] is pushed into the FIFO.
- **Overflow:**
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped. drop_cnt increments, saturating at 255.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted. Occupancy stays at DEPTH.
- **FIFO storage:** circular buffer with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. fifo_full and fifo_empty decode that counter.
- **Drain FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:**
  - IDLE: if !fifo_empty and !tx_busy, pop the head into tx_data and go to START. Otherwise stay.
  - START: tx_start=1. Go to WAIT_BUSY unconditionally and clear the timeout counter.
  - WAIT_BUSY:
    - tx_busy=1 → go to WAIT_DONE.
    - Otherwise increment the timeout counter. On reaching BUSY_TIMEOUT, go to IDLE; the byte is considered sent.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- **Simultaneous push and pop on a non-full FIFO:** both happen; occupancy unchanged.
- **tx_data hold:** tx_data holds its value from the pop until the next pop.

## Timing
- **Reset values:** state=IDLE, pointers and occupancy 0, fifo_empty=1, fifo_full=0, tx_start=0, tx_data=8'h00, hex_data=16'h0000, drop_cnt=0.
- **Reset mid-operation:**
  - tx_start falls immediately on rst_n low.
  - The FIFO is flushed and queued bytes are lost.
  - The FSM returns to IDLE regardless of tx_busy.
- **Registered outputs:** tx_start is decoded from the registered state (state==START), so it is glitch-free.
- **Latency, UART store to start:**
  - Store sampled at edge E0 with an idle transmitter.
  - fifo_empty=0 after E0.
  - Pop and transition to START at E1.
  - tx_start high from E1 to E2, with tx_data valid.
  - FSM in WAIT_BUSY after E2.
- **Handshake:**
  - The transmitter samples tx_start=1 at E2 and raises tx_busy after E2.
  - The next pop occurs no earlier than one cycle after tx_busy falls.
- **Throughput:** one byte per UART frame + 3 cycles of overhead.
- **Hex update:** visible on hex_data one cycle after the store edge.
- **Flag timing:** fifo_full, fifo_empty and drop_cnt update on the edge of the push or pop causing the change.

## Test plan
- **Reset:** assert rst_n=0 mid-frame with 3 bytes queued → all outputs at reset values immediately; after release, no tx_start with tx_busy=0.
- **Hex store:** store 16'hBEEF to addr 0 → hex_data=16'hBEEF next cycle; FIFO stays empty; no tx_start.
- **Single byte:**
  - Store 8'h41 to addr 1; transmitter model raises busy 1 cycle after start and holds it 10 cycles.
  - Expect exactly one tx_start pulse, at E1, with tx_data=8'h41.
  - FSM returns to IDLE after busy falls.
- **Burst overflow (DEPTH=4):**
  - Store 6 bytes 8'h01..8'h06 on consecutive cycles while tx_busy is held high.
  - Expect 4 bytes queued, fifo_full=1, drop_cnt=2.
  - After busy releases, 01..04 are sent in order.
- **Full with pop:** FIFO full, tx_busy falls; a store lands in the same cycle as the pop → store accepted; drop_cnt unchanged; FIFO still full.
- **Busy timeout:**
  - tx_busy tied 0.
  - Store 8'h55 then 8'h66.
  - Expect tx_start for 55, IDLE after 4 WAIT_BUSY cycles, then tx_start for 66.
  - drop_cnt remains 0.

Source files
------------

// File: rtl/mmio_tx_sched_if.sv
// Bundle between the memory decoder, the scheduler and the UART transmitter.
// Latency: none; this is wiring only.
// Backpressure: none of its own. tx_busy is the only flow control and is carried here.
//
// master: the CPU-side decoder plus the transmitter (drives the stores and tx_busy).
// slave : mmio_tx_sched (drives the hex register, the byte/start pair and the FIFO status).
interface mmio_tx_sched_if;
  logic        mmio_addr;   // 0 = hex display, 1 = UART TX
  logic [15:0] mmio_data;   // store data; the UART uses [7:0]
  logic        mmio_we;     // one-cycle store strobe
  logic [15:0] hex_data;    // registered hex display value
  logic [7:0]  tx_data;     // byte presented to the transmitter
  logic        tx_start;    // one-cycle start pulse
  logic        tx_busy;     // transmitter is shifting a frame
  logic        fifo_full;   // FIFO holds DEPTH entries
  logic        fifo_empty;  // FIFO holds no entries
  logic [7:0]  drop_cnt;    // UART stores lost to overflow, saturating

  modport master (
    output mmio_addr, mmio_data, mmio_we, tx_busy,
    input  hex_data, tx_data, tx_start, fifo_full, fifo_empty, drop_cnt
  );

  modport slave (
    input  mmio_addr, mmio_data, mmio_we, tx_busy,
    output hex_data, tx_data, tx_start, fifo_full, fifo_empty, drop_cnt
  );
endinterface

// File: rtl/mmio_tx_sched.sv
// Purpose: sequences CPU MMIO stores to the hex display register and, through a small FIFO, to the UART.
// Latency: hex store visible 1 cycle later; UART store to tx_start is 1 cycle on an idle transmitter.
// Backpressure: none toward the CPU. A store to a full FIFO is dropped unless a pop frees a slot in the same cycle.
//
// Ports: clk, rst_n (async, active low); bus (slave modport of mmio_tx_sched_if):
//   in : mmio_addr, mmio_data, mmio_we, tx_busy
//   out: hex_data, tx_data, tx_start, fifo_full, fifo_empty, drop_cnt
// DEPTH must be a power of two and at least 2. BUSY_TIMEOUT must be at least 1.
module mmio_tx_sched #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_tx_sched_if.slave bus
);

  localparam int AW = $clog2(DEPTH);           // pointer width
  localparam int CW = AW + 1;                  // occupancy width, holds 0..DEPTH
  localparam int TW = $clog2(BUSY_TIMEOUT + 1); // timeout counter width, holds 0..BUSY_TIMEOUT

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [15:0]   hex_q;
  logic [7:0]    tx_data_q;
  logic [7:0]    drop_q;

  logic full, empty;
  logic push_req, push_ok, drop;
  logic pop;

  // FIFO status decoded from the occupancy counter.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still accepts a store when the drain pops in the same cycle:
  // the slot being read is freed at the very edge the new byte is written.
  assign push_req = bus.mmio_we & bus.mmio_addr;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign to_cnt_inc = to_cnt_q + TW'(1);

  // Drain FSM: next state, pop request and timeout counter.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          // A transmitter that never acknowledges is treated as having sent
          // the byte, so a dead UART cannot wedge the queue.
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == TW'(BUSY_TIMEOUT)) begin
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push_ok && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage carries no reset; resetting the pointers and occupancy is what
  // discards queued bytes.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.mmio_data[7:0];
    end
  end

  // Hex register, transmit byte latch and the saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q     <= 16'h0000;
      tx_data_q <= 8'h00;
      drop_q    <= 8'h00;
    end else begin
      if (bus.mmio_we && !bus.mmio_addr) begin
        hex_q <= bus.mmio_data;
      end
      // The head is read before this edge's write, so a same-cycle push into
      // the slot being freed does not disturb the popped byte.
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // tx_start comes straight from the state register, so it is glitch-free
  // and drops as soon as reset is asserted.
  assign bus.tx_start   = (state_q == START);
  assign bus.tx_data    = tx_data_q;
  assign bus.hex_data   = hex_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_mmio_tx_sched.sv
// Bench for mmio_tx_sched: directed cases plus randomized stores, with a
// queue-based reference model, a responsive transmitter model and a
// scoreboard monitor that checks every start pulse and the status outputs.
module tb_mmio_tx_sched;
  localparam int DEPTH = 4;
  localparam int TO    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mmio_tx_sched_if bus ();

  mmio_tx_sched #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transmitter model ----------------
  logic xmit_busy  = 1'b0;
  logic force_busy = 1'b0;
  bit   respond    = 1'b1;   // 0: transmitter never raises busy
  int   fixed_len  = 10;     // >0: every frame this many cycles; 0: length from byte
  int   fb_mode    = 0;      // 0 release, 1 hold, 2 random force of tx_busy

  assign bus.tx_busy = xmit_busy | force_busy;

  function automatic int len_of(input logic [7:0] b);
    return (fixed_len > 0) ? fixed_len : int'(b % 8'd6) + 1;
  endfunction

  int  busy_left = 0;
  int  arm_len   = 0;
  bit  arm       = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left = 0;
      arm       = 1'b0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (arm) begin
        busy_left = arm_len;
        arm       = 1'b0;
      end
      if (bus.tx_start && respond) begin
        arm     = 1'b1;
        arm_len = len_of(bus.tx_data);
      end
    end
    xmit_busy = (busy_left > 0);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t        sb_q[$];     // expected start pulses: byte and edge number
  logic [7:0]  mq[$];       // bytes waiting in the FIFO
  int          free_at;     // first edge at which the drainer may pop again
  logic [15:0] exp_hex;
  logic [7:0]  exp_drop;
  logic        exp_full;
  logic        exp_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    free_at   = 0;
    exp_hex   = 16'h0000;
    exp_drop  = 8'h00;
    exp_full  = 1'b0;
    exp_empty = 1'b1;
  endtask

  // Predicts the effect of the coming edge n from the drainer's availability,
  // the queue contents and the store being presented.
  task automatic model_step(input bit we, input bit addr, input logic [15:0] d);
    int         n;
    bit         was_full;
    bit         popped;
    logic [7:0] b;
    n        = cyc + 1;
    was_full = (mq.size() == DEPTH);
    popped   = (n >= free_at) && (mq.size() > 0) && !force_busy;
    if (popped) begin
      b = mq.pop_front();
      sb_q.push_back('{b: b, c: n});
      // responsive frame: start, busy seen, L busy cycles, idle again = L+3
      // unanswered start: start, then the timeout window, then idle = TO+2
      free_at = n + (respond ? len_of(b) + 3 : TO + 2);
    end
    if (we && addr) begin
      if (!was_full || popped) mq.push_back(d[7:0]);
      else if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    end
    if (we && !addr) exp_hex = d;
    exp_full  = (mq.size() == DEPTH);
    exp_empty = (mq.size() == 0);
  endtask

  // One clock of stimulus, driven at the falling edge.
  task automatic cycle(input bit we, input bit addr, input logic [15:0] d);
    @(negedge clk);
    case (fb_mode)
      0: force_busy = 1'b0;
      1: force_busy = 1'b1;
      default: begin
        if (force_busy) begin
          if ($urandom_range(5, 0) == 0) force_busy = 1'b0;
        end else if ((cyc + 1 >= free_at) && ($urandom_range(11, 0) == 0)) begin
          force_busy = 1'b1;
        end
      end
    endcase
    bus.mmio_we   = we;
    bus.mmio_addr = addr;
    bus.mmio_data = d;
    if (rst_n) model_step(we, addr, d);
  endtask

  task automatic drain();
    bit done;
    done    = 1'b0;
    fb_mode = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      if ((mq.size() == 0) && (cyc + 1 >= free_at)) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: queue not drained within 600 cycles, %0d bytes left", mq.size());
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_hex_data", bus.hex_data, 16'h0000);
    chk("rst_drop_cnt", bus.drop_cnt, 8'h00);
    chk("rst_fifo_empty", bus.fifo_empty, 1'b1);
    chk("rst_fifo_full", bus.fifo_full, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    bit   exp_start;
    #3;
    if (!rst_n) sb_q.delete();
    chk("hex_data", bus.hex_data, exp_hex);
    chk("drop_cnt", bus.drop_cnt, exp_drop);
    chk("fifo_full", bus.fifo_full, exp_full);
    chk("fifo_empty", bus.fifo_empty, exp_empty);
    exp_start = (sb_q.size() > 0) && (sb_q[0].c == cyc);
    chk("tx_start", bus.tx_start, exp_start);
    if (exp_start) begin
      e = sb_q.pop_front();
      if (bus.tx_start) chk("tx_data", bus.tx_data, e.b);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.mmio_we   = 1'b0;
    bus.mmio_addr = 1'b0;
    bus.mmio_data = 16'h0000;
    model_reset();
    #2;
    chk_reset_values();
    repeat (2) cycle(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;

    // hex store
    cycle(1'b1, 1'b0, 16'hBEEF);
    repeat (3) cycle(1'b0, 1'b0, 16'h0000);

    // single byte, 10-cycle frame
    respond   = 1'b1;
    fixed_len = 10;
    cycle(1'b1, 1'b1, 16'h0041);
    drain();

    // burst of six with busy held: four queued, two dropped
    fb_mode = 1;
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b1, 16'(i));
    // busy falls and a store lands on the popping edge
    fb_mode = 0;
    cycle(1'b1, 1'b1, 16'h0007);
    drain();

    // reset in the middle of a frame with three bytes queued
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h0011 + 16'(i));
    repeat (4) cycle(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    bus.mmio_we = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    #1;
    chk_reset_values();
    repeat (3) cycle(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    repeat (15) cycle(1'b0, 1'b0, 16'h0000);

    // transmitter never answers: each byte times out
    respond = 1'b0;
    cycle(1'b1, 1'b1, 16'h0055);
    cycle(1'b1, 1'b1, 16'h0066);
    drain();

    // randomized stores, responsive transmitter with byte-dependent frames
    respond   = 1'b1;
    fixed_len = 0;
    fb_mode   = 2;
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), 16'($urandom));
    drain();

    // randomized stores, silent transmitter
    respond = 1'b0;
    fb_mode = 2;
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), 16'($urandom));
    drain();

    // drop counter saturation
    respond = 1'b1;
    fb_mode = 1;
    for (int i = 0; i < 264; i++) cycle(1'b1, 1'b1, 16'(i));
    drain();

    repeat (3) cycle(1'b0, 1'b0, 16'h0000);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
